alu_share_arbiter: RTL and testbench

- Shares the single combinational `alu` datapath between two requesters (e.g. execute path and address-generation/debug path).
- Round-robin arbiter with valid/ready request and response handshakes.
- Operands are registered into the ALU for one issue cycle, then the result and zero flag are held until the winning requester accepts them.
- Sits between the requesters and the `alu` instance; it is the only driver of the ALU inputs.

---
 rtl/alu_share_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            valid/ready requesters; result held until the owner accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_data1,
  input  logic [WIDTH-1:0]  req0_data2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_imm,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_data1,
  input  logic [WIDTH-1:0]  req1_data2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_imm,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  alu_data1,
  output logic [WIDTH-1:0]  alu_data2,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_imm,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  served0,
  output logic [CNT_W-1:0]  served1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  // All-ones control code makes the ALU output 0 while idle.
  localparam logic [CTRL_W-1:0] C_CTRL_DEFAULT = {CTRL_W{1'b1}};
  localparam logic [CNT_W-1:0]  C_CNT_ONE      = CNT_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_gid;
  logic              r_last_grant;
  logic [WIDTH-1:0]  r_alu_data1;
  logic [WIDTH-1:0]  r_alu_data2;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [WIDTH-1:0]  r_alu_imm;
  logic [WIDTH-1:0]  r_rsp_result;
  logic              r_rsp_zero;
  logic [CNT_W-1:0]  r_served0;
  logic [CNT_W-1:0]  r_served1;

  logic              w_any_valid;
  logic              w_grant_id;
  logic              w_accept;
  logic              w_rsp_take;

  // A tie goes to whoever did not win last; otherwise the lone requester wins.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept    = (r_state == S_IDLE) & w_any_valid;
  assign w_rsp_take  = (r_state == S_RESP) & (r_gid ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_ISSUE;
      S_ISSUE:                 w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_take) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid & ~w_grant_id;
        req1_ready = req1_valid &  w_grant_id;
      end
      S_ISSUE: begin
        busy = 1'b1;
      end
      S_RESP: begin
        busy       = 1'b1;
        rsp0_valid = ~r_gid;
        rsp1_valid =  r_gid;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Grant bookkeeping and ALU operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gid        <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_data1  <= '0;
      r_alu_data2  <= '0;
      r_alu_ctrl   <= C_CTRL_DEFAULT;
      r_alu_imm    <= '0;
    end else if (w_accept) begin
      r_gid        <= w_grant_id;
      r_last_grant <= w_grant_id;
      r_alu_data1  <= w_grant_id ? req1_data1 : req0_data1;
      r_alu_data2  <= w_grant_id ? req1_data2 : req0_data2;
      r_alu_ctrl   <= w_grant_id ? req1_ctrl  : req0_ctrl;
      r_alu_imm    <= w_grant_id ? req1_imm   : req0_imm;
    end else if (r_state == S_ISSUE) begin
      // Operands stay put; only the control code is parked.
      r_alu_ctrl   <= C_CTRL_DEFAULT;
    end
  end

  // Captured response and served counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_served0    <= '0;
      r_served1    <= '0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
      end
      if (w_rsp_take) begin
        if (r_gid) begin
          r_served1 <= r_served1 + C_CNT_ONE;
        end else begin
          r_served0 <= r_served0 + C_CNT_ONE;
        end
      end
    end
  end

  assign alu_data1  = r_alu_data1;
  assign alu_data2  = r_alu_data2;
  assign alu_ctrl   = r_alu_ctrl;
  assign alu_imm    = r_alu_imm;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign served0    = r_served0;
  assign served1    = r_served1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed table-driven bench for alu_share_arbiter with a small
//            reference ALU; counters use CNT_W=4 so wrap is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0]  req0_data1, req0_data2, req0_imm;
  logic [WIDTH-1:0]  req1_data1, req1_data2, req1_imm;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_zero;
  logic [WIDTH-1:0]  alu_data1, alu_data2, alu_imm, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_zero;
  logic              busy;
  logic [CNT_W-1:0]  served0, served1;

  alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_ctrl(req0_ctrl), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_ctrl(req1_ctrl), .req1_imm(req1_imm),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
    .alu_imm(alu_imm), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .served0(served0), .served1(served1)
  );

  // Reference ALU: 0000 AND, 0001 OR, 0010 ADD, 0011 ADDI, 0110 SUB, else 0.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0011: alu_result = alu_data1 + alu_imm;
      4'b0110: alu_result = alu_data1 - alu_data2;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [3:0]  ctl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] res;
    logic        z;
    int          hold;
  } vec_t;

  vec_t        vecs [8];
  int          n_chk;
  int          n_fail;
  logic [3:0]  exp_s0;
  logic [3:0]  exp_s1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic id, input logic [3:0] ctl, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm);
    if (id) begin
      req1_ctrl = ctl; req1_data1 = d1; req1_data2 = d2; req1_imm = imm;
    end else begin
      req0_ctrl = ctl; req0_data1 = d1; req0_data2 = d2; req0_imm = imm;
    end
  endtask

  // Called just after a negedge with valids already driven; returns just after
  // the negedge following the response handshake (back in IDLE).
  task automatic serve(input logic id, input logic [3:0] ctl, input logic [31:0] d1,
                       input logic [31:0] res, input logic z, input int hold,
                       input logic drop, input logic raise0);
    int t;
    t = 0;
    #1;
    while (!(req0_ready || req1_ready) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("req_ready_seen", {31'd0, req0_ready | req1_ready}, 32'd1);
    chk("grant_id", {31'd0, req1_ready}, {31'd0, id});
    chk("single_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (drop) begin
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    if (raise0) req0_valid = 1'b1;
    #1;
    chk("issue_busy", {31'd0, busy}, 32'd1);
    chk("issue_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("issue_rsp_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("issue_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ctl});
    chk("issue_alu_data1", alu_data1, d1);
    @(negedge clk); #1;
    chk("rsp_owner_valid", {31'd0, id ? rsp1_valid : rsp0_valid}, 32'd1);
    chk("rsp_other_valid", {31'd0, id ? rsp0_valid : rsp1_valid}, 32'd0);
    chk("rsp_result", rsp_result, res);
    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, z});
    chk("resp_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    for (int k = 0; k < hold; k++) begin
      // Non-owner's ready must be ignored while stalled.
      if (id) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      @(negedge clk); #1;
      chk("hold_valid", {31'd0, id ? rsp1_valid : rsp0_valid}, 32'd1);
      chk("hold_result", rsp_result, res);
      chk("hold_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    if (id) exp_s1 = exp_s1 + 4'd1; else exp_s0 = exp_s0 + 4'd1;
    #1;
    chk("served0", {28'd0, served0}, {28'd0, exp_s0});
    chk("served1", {28'd0, served1}, {28'd0, exp_s1});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_rsp_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_s0 = '0; exp_s1 = '0;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    set_req(1'b1, 4'd0, 32'd0, 32'd0, 32'd0);

    vecs[0] = '{1'b0, 4'b0010, 32'd5,          32'd7,          32'd0,     32'd12,         1'b0, 0};
    vecs[1] = '{1'b1, 4'b0110, 32'd9,          32'd9,          32'd0,     32'd0,          1'b1, 0};
    vecs[2] = '{1'b0, 4'b0000, 32'h0000F0F0,   32'h00000FF0,   32'd0,     32'h000000F0,   1'b0, 2};
    vecs[3] = '{1'b1, 4'b0001, 32'h00FF0000,   32'h0000FF00,   32'd0,     32'h00FFFF00,   1'b0, 0};
    vecs[4] = '{1'b0, 4'b0011, 32'd100,        32'd0,          32'hFFF,   32'd4195,       1'b0, 0};
    vecs[5] = '{1'b1, 4'b1111, 32'd3,          32'd4,          32'd0,     32'd0,          1'b1, 1};
    vecs[6] = '{1'b0, 4'b0110, 32'd0,          32'd1,          32'd0,     32'hFFFFFFFF,   1'b0, 0};
    vecs[7] = '{1'b1, 4'b0010, 32'hFFFFFFFF,   32'd1,          32'd0,     32'd0,          1'b1, 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("rst_alu_data1", alu_data1, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_served", {24'd0, served1, served0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single requests from the table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_req(vecs[i].id, vecs[i].ctl, vecs[i].d1, vecs[i].d2, vecs[i].imm);
      if (vecs[i].id) req1_valid = 1'b1; else req0_valid = 1'b1;
      serve(vecs[i].id, vecs[i].ctl, vecs[i].d1, vecs[i].res, vecs[i].z,
            vecs[i].hold, 1'b1, 1'b0);
    end

    // Backpressure on req1 while req0 waits, then req0 goes next
    @(negedge clk);
    set_req(1'b1, 4'b0010, 32'd1, 32'd1, 32'd0);
    set_req(1'b0, 4'b0110, 32'd20, 32'd8, 32'd0);
    req1_valid = 1'b1;
    serve(1'b1, 4'b0010, 32'd1, 32'd2, 1'b0, 5, 1'b1, 1'b1);
    chk("bp_req0_granted_next", {31'd0, req0_ready}, 32'd1);
    serve(1'b0, 4'b0110, 32'd20, 32'd12, 1'b0, 0, 1'b1, 1'b0);

    // Reset while a result is pending in RESP
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("mr_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("mr_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("mr_result", rsp_result, 32'd12);
    reset = 1'b1;
    #1;
    chk("mr_rsp_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("mr_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("mr_served", {24'd0, served1, served0}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_result_clr", rsp_result, 32'd0);
    exp_s0 = '0; exp_s1 = '0;
    @(negedge clk);
    reset = 1'b0;

    // Both valid continuously: grants alternate starting with req0
    @(negedge clk);
    set_req(1'b0, 4'b0110, 32'd20, 32'd8, 32'd0);
    set_req(1'b1, 4'b0011, 32'd100, 32'd0, 32'h00000FFF);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) serve(1'b0, 4'b0110, 32'd20, 32'd12, 1'b0, 0, 1'b0, 1'b0);
      else            serve(1'b1, 4'b0011, 32'd100, 32'd4195, 1'b0, 0, 1'b0, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Counter wrap: 16 more req0 ops bring served0 back to its start value
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      set_req(1'b0, 4'b0010, k, 32'd1, 32'd0);
      req0_valid = 1'b1;
      serve(1'b0, 4'b0010, k, k + 1, 1'b0, 0, 1'b1, 1'b0);
    end
    chk("wrap_served0", {28'd0, served0}, 32'd2);

    // Idle: nothing requested
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("idle_state", {28'd0, busy, req1_ready, req0_ready, rsp0_valid | rsp1_valid}, 32'd0);
      chk("idle_ctrl", {28'd0, alu_ctrl}, 32'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
